// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter: registered grant, per-master burst limit, no idle cycle on handover.
// Optional watchdog that aborts a stalled transaction: define BUS_ARB_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no owner; bus_en held low, next request (tie -> ~last) is granted
// ST_OWN   | master gid_q owns the controller port
module bus_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_en,
  input  logic        m1_en,
  input  logic        m0_wr,
  input  logic        m1_wr,
  input  logic [1:0]  m0_size,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_data_out,
  input  logic [31:0] m1_data_out,
  output logic [31:0] m0_data_in,
  output logic [31:0] m1_data_in,
  output logic        m0_wt,
  output logic        m1_wt,
  output logic        bus_en,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data_out,
  input  logic [31:0] bus_data_in,
  input  logic        bus_wt,
  output logic        gnt_valid,
  output logic        gnt_id,
  output logic        bus_err
);

  if (BURST_MAX < 1 || BURST_MAX > 15) begin : g_bad_burst
    $error("bus_arbiter: BURST_MAX must be in 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT must be in 1..255");
  end

  localparam logic [4:0] BURST_LIM = 5'(BURST_MAX);

  typedef enum logic {ST_IDLE = 1'b0, ST_OWN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic       gid_q, gid_d;
  logic       last_q, last_d;
  logic [3:0] bcnt_q, bcnt_d;

  logic own_en;
  logic oth_en;
  logic abort;
  logic complete;
  logic own;

  assign own    = (state_q == ST_OWN);
  assign own_en = gid_q ? m1_en : m0_en;
  assign oth_en = gid_q ? m0_en : m1_en;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wdog_q, wdog_d;

  // Abort fires in the TIMEOUT-th consecutive stalled cycle.
  assign abort = own && own_en && bus_wt && (wdog_q == WDOG_LAST);

  always_comb begin
    wdog_d = wdog_q;
    if (!own || !own_en || complete) begin
      wdog_d = '0;
    end else if (bus_wt) begin
      wdog_d = wdog_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  assign abort = 1'b0;
`endif

  assign complete = own && own_en && (!bus_wt || abort);
  assign bus_err  = abort;

  assign gnt_valid = own;
  assign gnt_id    = gid_q;

  always_comb begin
    bus_en       = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = '0;
    bus_addr     = '0;
    bus_data_out = '0;
    if (own) begin
      if (gid_q) begin
        bus_en       = m1_en;
        bus_wr       = m1_wr;
        bus_size     = m1_size;
        bus_addr     = m1_addr;
        bus_data_out = m1_data_out;
      end else begin
        bus_en       = m0_en;
        bus_wr       = m0_wr;
        bus_size     = m0_size;
        bus_addr     = m0_addr;
        bus_data_out = m0_data_out;
      end
      if (abort) begin
        bus_en = 1'b0;
      end
    end
  end

  assign m0_wt = (own && !gid_q) ? (bus_wt && !abort) : 1'b1;
  assign m1_wt = (own &&  gid_q) ? (bus_wt && !abort) : 1'b1;

  assign m0_data_in = (abort && !gid_q) ? '0 : bus_data_in;
  assign m1_data_in = (abort &&  gid_q) ? '0 : bus_data_in;

  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    last_d  = last_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_en || m1_en) begin
          state_d = ST_OWN;
          gid_d   = (m0_en && m1_en) ? !last_q : m1_en;
          bcnt_d  = '0;
        end
      end
      default: begin
        if (complete && oth_en && (({1'b0, bcnt_q} + 5'd1) == BURST_LIM)) begin
          gid_d  = !gid_q;
          last_d = gid_q;
          bcnt_d = '0;
        end else if (complete) begin
          if (bcnt_q != 4'hF) begin
            bcnt_d = bcnt_q + 4'd1;
          end
        end else if (!own_en) begin
          // Owner went idle (or dropped en mid-wait): release to the other master if it waits.
          last_d = gid_q;
          if (oth_en) begin
            gid_d  = !gid_q;
            bcnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      gid_q   <= 1'b0;
      last_q  <= 1'b1;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (BURST_MAX=2, TIMEOUT=8): grant latency, round-robin handover,
// stall handling, asynchronous reset, and the watchdog abort when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        m0_en, m1_en, m0_wr, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_addr, m1_addr, m0_data_out, m1_data_out;
  logic [31:0] m0_data_in, m1_data_in;
  logic        m0_wt, m1_wt;
  logic        bus_en, bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_data_out, bus_data_in;
  logic        bus_wt;
  logic        gnt_valid, gnt_id, bus_err;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h2000_0000;
  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] D1 = 32'hB1B1_0000;

  bus_arbiter #(.BURST_MAX(2), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .m0_en(m0_en), .m1_en(m1_en), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_size(m0_size), .m1_size(m1_size), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_data_out(m0_data_out), .m1_data_out(m1_data_out),
    .m0_data_in(m0_data_in), .m1_data_in(m1_data_in),
    .m0_wt(m0_wt), .m1_wt(m1_wt),
    .bus_en(bus_en), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
    .bus_data_out(bus_data_out), .bus_data_in(bus_data_in), .bus_wt(bus_wt),
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0]  pat;
    logic [31:0] rd;
    pat = 6'b001100;
    reset = 1'b0;
    m0_en = 1'b0; m1_en = 1'b0;
    m0_wr = 1'b1; m1_wr = 1'b0;
    m0_size = 2'd2; m1_size = 2'd1;
    m0_addr = A0; m1_addr = A1;
    m0_data_out = D0; m1_data_out = D1;
    bus_data_in = '0; bus_wt = 1'b1;

    #2;
    chk("rst_gnt_valid", gnt_valid, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_bus_en", bus_en, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_m0_wt", m0_wt, 1);
    chk("rst_m1_wt", m1_wt, 1);
    chk("rst_bus_err", bus_err, 0);
    #10 reset = 1'b1;

    // Single master: one-cycle grant latency, pass-through routing.
    cyc(); m0_en = 1'b1; #1;
    chk("t1_pre_bus_en", bus_en, 0);
    cyc();
    chk("t1_gnt_valid", gnt_valid, 1);
    chk("t1_gnt_id", gnt_id, 0);
    chk("t1_bus_en", bus_en, 1);
    chk("t1_bus_addr", bus_addr, A0);
    chk("t1_bus_data_out", bus_data_out, D0);
    chk("t1_bus_wr", bus_wr, 1);
    chk("t1_bus_size", bus_size, 2);
    chk("t1_m0_wt_stall", m0_wt, 1);
    chk("t1_m1_wt", m1_wt, 1);
    bus_wt = 1'b0; bus_data_in = 32'h1111_1111; #1;
    chk("t1_m0_wt_done", m0_wt, 0);
    chk("t1_m0_data_in", m0_data_in, 32'h1111_1111);
    chk("t1_m1_wt_done", m1_wt, 1);
    cyc(); m0_en = 1'b0; bus_wt = 1'b1; #1;
    chk("t1_hold_gnt", gnt_valid, 1);
    chk("t1_bus_en_drop", bus_en, 0);
    cyc();
    chk("t1_release", gnt_valid, 0);
    chk("t1_release_addr", bus_addr, 0);

    // Fresh reset, simultaneous requests, continuous completions: 0,0,1,1,0,0.
    reset = 1'b0; #1; reset = 1'b1;
    cyc(); m0_en = 1'b1; m1_en = 1'b1; bus_wt = 1'b0; #1;
    chk("t2_pre_gnt_valid", gnt_valid, 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      rd = 32'hD000_0010 + 32'(i);
      bus_data_in = rd; #1;
      chk("t2_gnt_valid", gnt_valid, 1);
      chk("t2_gnt_id", gnt_id, {31'd0, pat[i]});
      chk("t2_bus_addr", bus_addr, pat[i] ? A1 : A0);
      chk("t2_owner_data_in", pat[i] ? m1_data_in : m0_data_in, rd);
      chk("t2_owner_wt", pat[i] ? m1_wt : m0_wt, 0);
      chk("t2_other_wt", pat[i] ? m0_wt : m1_wt, 1);
    end
    m0_en = 1'b0; m1_en = 1'b0;
    cyc();
    chk("t2_idle", gnt_valid, 0);

    // m1 stalls 3 cycles while m0 waits; m0 takes over after m1 releases.
    m1_en = 1'b1; bus_wt = 1'b1;
    cyc();
    chk("t4_gnt_id", gnt_id, 1);
    chk("t4_m1_wt", m1_wt, 1);
    m0_en = 1'b1; #1;
    chk("t4_m0_wt_s1", m0_wt, 1);
    cyc();
    chk("t4_gnt_id_s2", gnt_id, 1);
    chk("t4_m0_wt_s2", m0_wt, 1);
    chk("t4_bus_addr", bus_addr, A1);
    cyc(); bus_wt = 1'b0; bus_data_in = 32'h2222_2222; #1;
    chk("t4_m1_wt_done", m1_wt, 0);
    chk("t4_m0_wt_s3", m0_wt, 1);
    chk("t4_m1_data_in", m1_data_in, 32'h2222_2222);
    cyc(); m1_en = 1'b0; bus_wt = 1'b1; #1;
    chk("t4_gnt_id_after", gnt_id, 1);
    chk("t4_m0_wt_after", m0_wt, 1);
    cyc();
    chk("t4_handover_valid", gnt_valid, 1);
    chk("t4_handover_id", gnt_id, 0);
    chk("t4_handover_en", bus_en, 1);
    chk("t4_handover_addr", bus_addr, A0);

    // Asynchronous reset while m0's transaction is in flight.
    reset = 1'b0; #1;
    chk("t5_bus_en", bus_en, 0);
    chk("t5_gnt_valid", gnt_valid, 0);
    chk("t5_m0_wt", m0_wt, 1);
    #1 reset = 1'b1;
    m1_en = 1'b1;
    cyc();
    chk("t5_tie_valid", gnt_valid, 1);
    chk("t5_tie_id", gnt_id, 0);
    bus_wt = 1'b0; #1;
    chk("t5_m0_wt_done", m0_wt, 0);
    cyc(); bus_wt = 1'b1; bus_data_in = 32'h5555_AAAA; #1;

`ifdef BUS_ARB_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      chk("t6_stall_err", bus_err, 0);
      chk("t6_stall_en", bus_en, 1);
      chk("t6_stall_wt", m0_wt, 1);
      cyc();
    end
    chk("t6_abort_wt", m0_wt, 0);
    chk("t6_abort_data", m0_data_in, 0);
    chk("t6_abort_other_data", m1_data_in, 32'h5555_AAAA);
    chk("t6_abort_err", bus_err, 1);
    chk("t6_abort_en", bus_en, 0);
    chk("t6_abort_m1_wt", m1_wt, 1);
    cyc();
    chk("t6_move_valid", gnt_valid, 1);
    chk("t6_move_id", gnt_id, 1);
    chk("t6_move_err", bus_err, 0);
    chk("t6_move_en", bus_en, 1);
`else
    for (int k = 0; k < 3; k++) begin
      chk("t6_stall_err", bus_err, 0);
      chk("t6_stall_id", gnt_id, 0);
      chk("t6_stall_wt", m0_wt, 1);
      cyc();
    end
    bus_wt = 1'b0; #1;
    cyc();
    chk("t6_move_valid", gnt_valid, 1);
    chk("t6_move_id", gnt_id, 1);
    chk("t6_move_err", bus_err, 0);
`endif
    chk("t6_move_addr", bus_addr, A1);

    m0_en = 1'b0; m1_en = 1'b0;
    cyc();
    chk("end_idle", gnt_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter in front of the system bus controller. It shares the single controller port between the CPU (master 0) and a DMA/blitter engine (master 1).
- Each master sees the same en/wr/size/addr/data/wt bus protocol it would see when attached directly to the controller.
- Grant is registered. Selection is round-robin with a per-master burst limit, so neither master can starve the other.
- Sits between the masters and the bus controller. It does no address decoding.

Parameters:
- BURST_MAX, 4: max back-to-back completed transactions one master may run while the other master is requesting (range 1..15).
- TIMEOUT, 255: bus watchdog limit in cycles. Used only with BUS_ARB_TIMEOUT_EN (range 1..255).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- m0_en, m1_en  in  1  master requests a transaction; held high until its wt is sampled low
- m0_wr, m1_wr  in  1  write (1) / read (0)
- m0_size, m1_size  in  2  access size, passed through unchanged
- m0_addr, m1_addr  in  32  byte address
- m0_data_out, m1_data_out  in  32  write data from master
- m0_data_in, m1_data_in  out  32  read data to master
- m0_wt, m1_wt  out  1  wait to master; low means the transaction completes this cycle
- bus_en  out  1  to controller cpu_en
- bus_wr  out  1  to controller cpu_wr
- bus_size  out  2  to controller cpu_size
- bus_addr  out  32  to controller cpu_addr
- bus_data_out  out  32  to controller cpu_data_out
- bus_data_in  in  32  from controller cpu_data_in
- bus_wt  in  1  from controller cpu_wt
- gnt_valid  out  1  registered: a master currently owns the bus
- gnt_id  out  1  registered: owning master (0/1), valid while gnt_valid=1
- bus_err  out  1  one-cycle pulse on watchdog abort; constant 0 without the macro

Behaviour:
- State registers:
  - own (gnt_valid)
  - gid (gnt_id)
  - last, the most recent owner, used for round-robin
  - bcnt[3:0], the burst counter
- Reset values: own=0, gid=0, last=1, bcnt=0, watchdog counter 0. With these values, master 0 wins the first tie.
- Output routing is combinational from the registered grant:
  - If own=1: bus_en/wr/size/addr/data_out come from master gid, with bus_en = m{gid}_en.
  - If own=0: bus_en=0, and bus_wr/size/addr/data_out are 0.
- Wait and read data:
  - m{gid}_wt = bus_wt when own=1.
  - Non-owner wt = 1 always. The owner's wt = 1 when own=0.
  - m0_data_in = m1_data_in = bus_data_in (broadcast). Data is only meaningful to the master whose wt is low.
- Completion event: own=1, m{gid}_en=1 and bus_wt=0, sampled at a rising edge.
- IDLE (own=0):
  - At the edge: if exactly one master has en=1, grant it. If both do, grant ~last.
  - Set own=1, gid=winner, bcnt=0.
  - Arbitration latency: 1 cycle from m_en high to bus_en high.
- OWN (own=1), evaluated at each edge in priority order:
  - Completion, other master requesting, and bcnt+1 == BURST_MAX: hand over directly. gid=~gid, last=old gid, bcnt=0. No idle cycle between the two masters.
  - Completion otherwise: keep the grant. bcnt = bcnt+1, saturating at 15.
  - Owner en=0 (between transactions): release. last=gid. If the other master is requesting, gid=~gid, bcnt=0, own stays 1; else own=0.
  - Otherwise (transaction in progress): hold.
- A master must not drop en while its wt is high. If it does, the arbiter treats it as a release at that edge and the controller sees bus_en fall.
- An owner with no competitor keeps the grant indefinitely, with bcnt saturating. Only a competing request with bcnt+1 == BURST_MAX forces a handover.
- Both masters raising en in the same cycle in IDLE: resolved by last.
- Reset asserted mid-transaction: all state clears immediately. bus_en drops asynchronously, and the in-flight transaction is abandoned.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts cycles with bus_en=1 and bus_wt=1. It clears on completion, on release, or when own=0.
  - When the count reaches TIMEOUT, the arbiter forces m{gid}_wt=0 and m{gid}_data_in=0 for one cycle, pulses bus_err=1 and drops bus_en in that cycle.
  - That cycle counts as a completion for bcnt and handover.
- Not defined:
  - No counter is built, and bus_err is tied to 0.
  - A slave that never drops wt stalls the owner forever.

Test Plan:
- Reset, then m0_en=1 at cycle 0 with m1 idle → bus_en=1 at cycle 1, gnt_id=0, m1_wt=1 throughout.
- m0_en and m1_en rise together from reset, bus_wt=0 always → m0 is granted first. m1 is granted immediately after m0's first completion, if m0 dropped en, or after BURST_MAX=4 completions.
- m0 issues continuous reads with m1 requesting, BURST_MAX=2 → grant pattern 0,0,1,1,0,0 with no idle cycle at handover. Each master's m_data_in matches the bus_data_in captured at its own completions.
- m1 owns the bus with bus_wt held high 3 cycles, then m0 requests → m0_wt stays 1, and m0 is granted only at the edge after m1's completion.
- Reset deasserted→asserted while bus_en=1 → bus_en, gnt_valid and bcnt go to 0 without waiting for a clock edge. After release, m0 wins the next tie.
- With BUS_ARB_TIMEOUT_EN, TIMEOUT=8 and bus_wt stuck at 1 → at the 8th stalled cycle: owner wt=0, data_in=0, bus_err=1 for one cycle, and the grant moves to the waiting master.
